// File: rtl/consec_rep_pkg.sv
// consec_rep_pkg: shared FSM state type and default burst-length limits
// for the consecutive-repetition pulse generator.
package consec_rep_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int DEF_MIN_REP = 2;
  localparam int DEF_MAX_REP = 4;
  localparam int DEF_CNT_W   = 8;

endpackage

// File: rtl/consec_rep_cnt.sv
// consec_rep_cnt: remaining-cycle counter for a burst. Loads the requested
// length, counts down once per decrement request and flags the last cycle.
module consec_rep_cnt
#(
  parameter int CNT_W = 8
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [CNT_W-1:0] len_i,
  output logic [CNT_W-1:0] rem_o,
  output logic             last_o
);

  logic [CNT_W-1:0] rem_q;
  logic [CNT_W-1:0] rem_d;

  // Next remaining count: load wins over decrement; never wraps below zero.
  always_comb begin
    rem_d = rem_q;
    if (load_i) begin
      rem_d = len_i;
    end else if (dec_i && (rem_q != '0)) begin
      rem_d = rem_q - 1'b1;
    end
  end

  // Remaining-count register, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= '0;
    end else begin
      rem_q <= rem_d;
    end
  end

  assign rem_o  = rem_q;
  assign last_o = (rem_q == CNT_W'(1));

endmodule

// File: rtl/consec_rep_gen.sv
// consec_rep_gen: generates a burst of len consecutive high cycles on sig
// for each accepted start request with MIN_REP <= len <= MAX_REP; flags
// out-of-range requests on err and the end of each burst on done.
// Optional macro CONSEC_REP_GEN_GAP_EN: removes the accept window in the
// last burst cycle, so every burst is preceded by at least one low cycle.
module consec_rep_gen
  import consec_rep_pkg::*;
#(
  parameter int MIN_REP = DEF_MIN_REP,
  parameter int MAX_REP = DEF_MAX_REP,
  parameter int CNT_W   = DEF_CNT_W
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  output logic             sig,
  output logic             busy,
  output logic             done,
  output logic             err
);

  if ((MIN_REP < 1) || (MAX_REP < MIN_REP) ||
      ((CNT_W < 31) && (MAX_REP >= (1 << CNT_W)))) begin : g_bad_param
    $error("consec_rep_gen: need 1 <= MIN_REP <= MAX_REP < 2**CNT_W");
  end

  localparam logic [CNT_W-1:0] MIN_L = CNT_W'(MIN_REP);
  localparam logic [CNT_W-1:0] MAX_L = CNT_W'(MAX_REP);

  // Unsigned range test at the full counter width.
  function automatic logic len_in_range(input logic [CNT_W-1:0] l);
    return (l >= MIN_L) && (l <= MAX_L);
  endfunction

  state_t           state_q;
  logic             sig_q;
  logic             done_q;
  logic             err_q;
  logic [CNT_W-1:0] rem;
  logic             last;
  logic             accept_d;
  logic             len_ok_d;
  logic             load_d;
  logic             dec_d;

  // Request acceptance: always in IDLE; in RUN only during the final cycle
  // unless the gap option forbids merging bursts.
  always_comb begin
    accept_d = 1'b0;
`ifdef CONSEC_REP_GEN_GAP_EN
    accept_d = start && (state_q == ST_IDLE);
`else
    accept_d = start && ((state_q == ST_IDLE) || ((state_q == ST_RUN) && last));
`endif
    len_ok_d = len_in_range(len);
    load_d   = accept_d && len_ok_d;
    dec_d    = (state_q == ST_RUN) && !load_d;
  end

  consec_rep_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .load_i (load_d),
    .dec_i  (dec_d),
    .len_i  (len),
    .rem_o  (rem),
    .last_o (last)
  );

  // IDLE/RUN FSM with registered sig, done and err outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sig_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= (state_q == ST_RUN) && last;
      err_q  <= accept_d && !len_ok_d;
      if (load_d) begin
        state_q <= ST_RUN;
        sig_q   <= 1'b1;
      end else if ((state_q == ST_RUN) && last) begin
        state_q <= ST_IDLE;
        sig_q   <= 1'b0;
      end
    end
  end

  assign sig  = sig_q;
  assign busy = sig_q;
  assign done = done_q;
  assign err  = err_q;

endmodule
